// File: rtl/mem_arb_pkg.sv
// Shared encodings for the unified memory port arbiter.
//   state_e : arbiter FSM state (IDLE=0, ISSUE=1, WAIT=2)
//   owner_e : which requester owns the in-flight transaction (OWN_IF=0, OWN_DM=1)
package mem_arb_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StIssue = 2'd1,
      StWait  = 2'd2
   } state_e;

   typedef enum logic {
      OwnIf = 1'b0,
      OwnDm = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection for the unified memory port.
// Data requests beat fetch. With MEM_ARB_STARVE_EN defined, a saturating streak counter
// hands the port to a waiting fetch after STREAK_MAX consecutive data grants.
// Ports:
//   i_clk, i_rst_n : clock / async active-low reset (only with MEM_ARB_STARVE_EN)
//   i_en           : grants allowed this cycle (arbiter is idle)
//   i_if_req       : fetch request
//   i_dm_req       : load or store request
//   o_if_gnt       : fetch granted
//   o_dm_gnt       : data granted
module mem_arb_pick #(
   parameter int unsigned STREAK_MAX = 4
) (
`ifdef MEM_ARB_STARVE_EN
   input  logic i_clk,
   input  logic i_rst_n,
`endif
   input  logic i_en,
   input  logic i_if_req,
   input  logic i_dm_req,
   output logic o_if_gnt,
   output logic o_dm_gnt
);

   if (STREAK_MAX < 1) begin : g_bad_streak
      $error("mem_arb_pick: STREAK_MAX must be at least 1");
   end

   logic starve;
   logic pick_dm;

`ifdef MEM_ARB_STARVE_EN
   localparam int unsigned CntW = $clog2(STREAK_MAX + 1);

   logic [CntW-1:0] streak_q, streak_d;

   assign starve = i_if_req && (streak_q == CntW'(STREAK_MAX));

   // Only data grants that actually make fetch wait extend the streak.
   always_comb begin
      streak_d = streak_q;
      if (o_if_gnt) begin
         streak_d = '0;
      end else if (o_dm_gnt) begin
         if (!i_if_req) begin
            streak_d = '0;
         end else if (streak_q != CntW'(STREAK_MAX)) begin
            streak_d = streak_q + 1'b1;
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         streak_q <= '0;
      end else begin
         streak_q <= streak_d;
      end
   end
`else
   assign starve = 1'b0;
`endif

   assign pick_dm  = i_dm_req && !starve;
   assign o_dm_gnt = i_en && pick_dm;
   assign o_if_gnt = i_en && i_if_req && !pick_dm;

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and load/store, one transaction at a time.
// Optional feature macro: MEM_ARB_STARVE_EN (fetch starvation guard, see mem_arb_pick).
// Ports:
//   i_clk, i_rst_n                         : clock, async active-low reset
//   i_if_req/i_if_addr, o_if_gnt           : fetch request / grant
//   o_if_rvalid/o_if_rdata                 : fetch response pulse / data
//   i_dm_ren/i_dm_wen/i_dm_addr/i_dm_wdata/i_dm_wmask, o_dm_gnt : data request / grant
//   o_dm_rvalid/o_dm_rdata                 : load data or store ack (data 0) pulse
//   o_mem_req/we/addr/wdata/wmask          : registered memory request
//   i_mem_ready                            : memory accepts request
//   i_mem_rvalid/i_mem_rdata               : memory response
//   o_busy                                 : transaction in flight
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W     = 32,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned STREAK_MAX = 4
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_if_req,
   input  logic [ADDR_W-1:0]   i_if_addr,
   output logic                o_if_gnt,
   output logic                o_if_rvalid,
   output logic [DATA_W-1:0]   o_if_rdata,
   input  logic                i_dm_ren,
   input  logic                i_dm_wen,
   input  logic [ADDR_W-1:0]   i_dm_addr,
   input  logic [DATA_W-1:0]   i_dm_wdata,
   input  logic [DATA_W/8-1:0] i_dm_wmask,
   output logic                o_dm_gnt,
   output logic                o_dm_rvalid,
   output logic [DATA_W-1:0]   o_dm_rdata,
   output logic                o_mem_req,
   output logic                o_mem_we,
   output logic [ADDR_W-1:0]   o_mem_addr,
   output logic [DATA_W-1:0]   o_mem_wdata,
   output logic [DATA_W/8-1:0] o_mem_wmask,
   input  logic                i_mem_ready,
   input  logic                i_mem_rvalid,
   input  logic [DATA_W-1:0]   i_mem_rdata,
   output logic                o_busy
);

   localparam int unsigned MaskW = DATA_W / 8;

   state_e              state_q, state_d;
   owner_e              owner_q, owner_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [DATA_W-1:0]   wdata_q, wdata_d;
   logic [MaskW-1:0]    wmask_q, wmask_d;
   logic                if_rvalid_q, if_rvalid_d;
   logic                dm_rvalid_q, dm_rvalid_d;
   logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

   logic if_gnt, dm_gnt;

   mem_arb_pick #(
      .STREAK_MAX (STREAK_MAX)
   ) u_pick (
`ifdef MEM_ARB_STARVE_EN
      .i_clk      (i_clk),
      .i_rst_n    (i_rst_n),
`endif
      .i_en       (state_q == StIdle),
      .i_if_req   (i_if_req),
      .i_dm_req   (i_dm_ren | i_dm_wen),
      .o_if_gnt   (if_gnt),
      .o_dm_gnt   (dm_gnt)
   );

   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      we_d        = we_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      wmask_d     = wmask_q;
      if_rvalid_d = 1'b0;
      dm_rvalid_d = 1'b0;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;

      unique case (state_q)
         StIdle: begin
            if (dm_gnt) begin
               // ren and wen together is treated as a store.
               owner_d = OwnDm;
               we_d    = i_dm_wen;
               addr_d  = i_dm_addr;
               wdata_d = i_dm_wen ? i_dm_wdata : '0;
               wmask_d = i_dm_wen ? i_dm_wmask : '0;
               state_d = StIssue;
            end else if (if_gnt) begin
               owner_d = OwnIf;
               we_d    = 1'b0;
               addr_d  = i_if_addr;
               wdata_d = '0;
               wmask_d = '0;
               state_d = StIssue;
            end
         end
         StIssue: begin
            if (i_mem_ready) begin
               state_d = StWait;
            end
         end
         StWait: begin
            if (i_mem_rvalid) begin
               if (owner_q == OwnDm) begin
                  dm_rvalid_d = 1'b1;
                  dm_rdata_d  = we_q ? '0 : i_mem_rdata;
               end else begin
                  if_rvalid_d = 1'b1;
                  if_rdata_d  = i_mem_rdata;
               end
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q     <= StIdle;
         owner_q     <= OwnIf;
         we_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         wmask_q     <= '0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         we_q        <= we_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         wmask_q     <= wmask_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
      end
   end

   assign o_if_gnt    = if_gnt;
   assign o_dm_gnt    = dm_gnt;
   assign o_if_rvalid = if_rvalid_q;
   assign o_if_rdata  = if_rdata_q;
   assign o_dm_rvalid = dm_rvalid_q;
   assign o_dm_rdata  = dm_rdata_q;
   assign o_mem_req   = (state_q == StIssue);
   assign o_mem_we    = we_q;
   assign o_mem_addr  = addr_q;
   assign o_mem_wdata = wdata_q;
   assign o_mem_wmask = wmask_q;
   assign o_busy      = (state_q != StIdle);

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares the core's single unified memory port between instruction fetch and the load/store stage, driven by the control unit's `o_mem_ren`/`o_mem_wen`. It carries one transaction at a time. Arbitration is fixed-priority: data beats fetch, with an optional starvation guard. The block sits between the pipeline front/back ends and the memory model and owns all request sequencing, response routing and busy indication.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width; the write mask is `DATA_W/8` bits
- `STREAK_MAX`, 4, consecutive data grants allowed while fetch waits; must be ≥1

Ports:
- `i_clk` in 1: clock; the only clock, all state on its rising edge
- `i_rst_n` in 1: reset, asynchronous, active-low
- `i_if_req` in 1: fetch request; held until granted
- `i_if_addr` in ADDR_W: fetch address
- `o_if_gnt` out 1: fetch request accepted this cycle
- `o_if_rvalid` out 1: one-cycle fetch data pulse
- `o_if_rdata` out DATA_W: fetched instruction
- `i_dm_ren` in 1: load request; held until granted
- `i_dm_wen` in 1: store request; held until granted
- `i_dm_addr` in ADDR_W: load/store address
- `i_dm_wdata` in DATA_W: store data
- `i_dm_wmask` in DATA_W/8: store byte enables
- `o_dm_gnt` out 1: data request accepted this cycle
- `o_dm_rvalid` out 1: one-cycle load data or store acknowledge
- `o_dm_rdata` out DATA_W: load data; 0 on a store acknowledge
- `o_mem_req` out 1: memory request valid
- `o_mem_we` out 1: memory write
- `o_mem_addr` out ADDR_W: memory address
- `o_mem_wdata` out DATA_W: memory write data
- `o_mem_wmask` out DATA_W/8: memory byte enables
- `i_mem_ready` in 1: memory accepts the request when `o_mem_req` && `i_mem_ready`
- `i_mem_rvalid` in 1: response for reads and writes; arrives ≥1 cycle after acceptance
- `i_mem_rdata` in DATA_W: read data
- `o_busy` out 1: a transaction is in flight (state ≠ IDLE)

## Operation
- State machine with three states:
  - IDLE: waits for a request.
  - ISSUE: drives `o_mem_req` from registers, holding all `o_mem_*` fields stable.
  - WAIT: waits for the memory response.
- IDLE transitions:
  - Any request → combinational winner selection, the matching `o_*_gnt` is asserted in that cycle, and the request fields plus the owner are captured at the clock edge → ISSUE.
  - No request → stay in IDLE.
- Winner selection:
  - Data wins if `i_dm_ren|i_dm_wen`; otherwise fetch wins.
  - The starvation guard can override this (see Configuration).
- If `i_dm_ren` and `i_dm_wen` are both high, the request is treated as a write.
- ISSUE: on `i_mem_ready` → WAIT; otherwise stay in ISSUE.
- WAIT: on `i_mem_rvalid`:
  - Register the response: the owner's `o_*_rvalid` pulses for exactly one cycle on the following cycle.
  - `o_*_rdata` = `i_mem_rdata` for a read, or 0 for a store acknowledge.
  - Go to IDLE.
- `i_mem_rvalid` in IDLE or ISSUE is ignored.
- Reset values: all outputs 0, state IDLE, owner fetch, streak counter 0.
- Reset asserted mid-transaction aborts it. Any later `i_mem_rvalid` for it is dropped and no `o_*_rvalid` is produced.
- `o_*_rdata` holds its last value between pulses.

## Timing
- Grant at cycle 0 (combinational, IDLE only).
- `o_mem_req` is high from cycle 1.
- Memory accepts at cycle 1 at the earliest; `i_mem_rvalid` arrives at cycle 2 at the earliest; `o_*_rvalid` pulses at cycle 3 at the earliest.
- A new grant is possible in the same cycle as the `o_*_rvalid` pulse (state is back in IDLE). Back-to-back throughput is therefore one transaction per 3 cycles minimum.
- Grants never occur outside IDLE, and at most one `o_*_gnt` is high in any cycle.

## Configuration
- `MEM_ARB_STARVE_EN` defined:
  - A saturating streak counter increments on each data grant made while `i_if_req` is high.
  - It clears on any fetch grant, and on a data grant made with `i_if_req` low.
  - When the counter equals `STREAK_MAX` and `i_if_req` is high, fetch wins even if data is requesting.
- `MEM_ARB_STARVE_EN` undefined: strict data priority. The counter logic is absent.

## Structure
- Shared package `mem_arb_pkg` holds:
  - state encoding (IDLE=0, ISSUE=1, WAIT=2)
  - owner encoding (OWN_IF=0, OWN_DM=1)
- One natural sub-module, `mem_arb_pick`: combinational winner selection plus the streak counter (the counter only when `MEM_ARB_STARVE_EN` is defined).
- The top level holds the FSM, request registers and response routing.

## Test plan
- Reset then single fetch: `i_if_addr`=0x100, ready immediately, rvalid 1 cycle later with 0x00000013 → `o_if_gnt` at c0, `o_mem_req` at c1, `o_if_rvalid`=1 with rdata 0x13 at c3 only.
- Simultaneous fetch 0x200 and load 0x1000 → `o_dm_gnt` first. The fetch stays pending and is granted in the cycle `o_dm_rvalid` pulses.
- Store of 0xDEADBEEF, mask 4'b0011, with `i_mem_ready` low for 3 cycles → `o_mem_*` fields stable throughout. `o_mem_we`=1, `o_dm_rvalid` pulses with rdata 0.
- `MEM_ARB_STARVE_EN`, `STREAK_MAX`=4, data requesting continuously and fetch held high → 4 data grants, then 1 fetch grant, then data again. Without the macro, fetch is never granted.
- `i_rst_n` low during WAIT, then a stray `i_mem_rvalid` → all outputs 0, no rvalid pulse, `o_busy`=0.
- `i_mem_rvalid` asserted in IDLE with no transaction → no state change, no pulse.
